// File: rtl/pmodcharlie_arbiter.sv
// pmodcharlie_arbiter: shares one 8-digit charlieplexed display among NUM_REQ
// requesters. The winner keeps the display for at least HOLD_CYCLES clocks.
// While it owns the display, the owner may replace its word, which restarts
// the hold. When the hold expires, ownership rotates round-robin.
//
// Handshake: a word on req_data[32*i +: 32] is accepted on a rising clk edge
// when req_valid[i] & req_ready[i]. req_ready is combinational and one-hot
// or zero. It may depend on req_valid, but req_valid must not depend on
// req_ready. A requester may withdraw req_valid at any time.
//
// The busy output is the FSM state as seen from outside (1 = HOLD, 0 = IDLE).
module pmodcharlie_arbiter #(
    parameter int          NUM_REQ       = 2,
    parameter real         CLK_FREQUENCY = 12E6,
    parameter int          HOLD_MS       = 500,
    parameter logic [31:0] IDLE_PATTERN  = 32'h0000_0000,
    parameter bit          BLANK_ON_IDLE = 1'b0
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [NUM_REQ-1:0]                          req_valid,
    input  logic [32*NUM_REQ-1:0]                       req_data,
    output logic [NUM_REQ-1:0]                          req_ready,
    output logic [31:0]                                 display_data,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] owner,
    output logic                                        busy
);

    localparam int HOLD_CYCLES = $rtoi($ceil(CLK_FREQUENCY * HOLD_MS / 1000.0));
    localparam int TW          = $clog2(HOLD_CYCLES + 1);
    localparam int OW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [TW-1:0] RELOAD = TW'(HOLD_CYCLES - 1);

    typedef enum logic {S_IDLE, S_HOLD} state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [31:0]     data_q, data_d;
    logic            busy_q, busy_d;

    logic            pick_found;
    logic [OW-1:0]   pick_idx;
    logic [OW-1:0]   scan_idx;
    logic            grant;

    // Round-robin pick. Start after the current owner. The owner is checked last.
    // The scan runs from the farthest offset to the nearest, so the nearest valid index wins.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = owner_q;
        scan_idx   = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            scan_idx = OW'((int'(owner_q) + k) % NUM_REQ);
            if (req_valid[scan_idx]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx;
            end
        end
    end

    // Next-state, handshake and display-word selection
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        owner_d   = owner_q;
        data_d    = data_q;
        req_ready = '0;
        grant     = 1'b0;

        case (state_q)
            S_IDLE: begin
                grant = pick_found;
            end
            S_HOLD: begin
                if (timer_q != '0) begin
                    // Only the owner may refresh its word. Each refresh restarts the hold.
                    if (req_valid[owner_q]) begin
                        req_ready[owner_q] = 1'b1;
                        data_d             = req_data[32*owner_q +: 32];
                        timer_d            = RELOAD;
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end else if (pick_found) begin
                    grant = 1'b1;
                end else begin
                    state_d = S_IDLE;
                    if (BLANK_ON_IDLE) begin
                        data_d = IDLE_PATTERN;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (grant) begin
            req_ready[pick_idx] = 1'b1;
            data_d              = req_data[32*pick_idx +: 32];
            owner_d             = pick_idx;
            timer_d             = RELOAD;
            state_d             = S_HOLD;
        end

        // During reset nothing is accepted
        if (rst) begin
            req_ready = '0;
        end

        busy_d = (state_d == S_HOLD);
    end

    // State, timer and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            owner_q <= OW'(NUM_REQ - 1);
            data_q  <= IDLE_PATTERN;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            owner_q <= owner_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
        end
    end

    assign display_data = data_q;
    assign owner        = owner_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_pmodcharlie_arbiter.sv
// Bench for pmodcharlie_arbiter.
// dut_a: NUM_REQ=2, keeps the last word when idle.
// dut_b: NUM_REQ=2, blanks to all-ones when idle.
// dut_c: NUM_REQ=4, round-robin and random stimulus.
// Every instance uses HOLD_CYCLES = 4.
module tb_pmodcharlie_arbiter;

  localparam int HC = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [1:0]   a_valid = '0, a_ready;
  logic [63:0]  a_data  = '0;
  logic [31:0]  a_disp;
  logic [0:0]   a_owner;
  logic         a_busy;

  logic [1:0]   b_valid = '0, b_ready;
  logic [63:0]  b_data  = '0;
  logic [31:0]  b_disp;
  logic [0:0]   b_owner;
  logic         b_busy;

  logic [3:0]   c_valid = '0, c_ready;
  logic [127:0] c_data  = '0;
  logic [31:0]  c_disp;
  logic [1:0]   c_owner;
  logic         c_busy;

  pmodcharlie_arbiter #(.NUM_REQ(2), .CLK_FREQUENCY(1E3), .HOLD_MS(4),
                        .IDLE_PATTERN(32'h0000_0000), .BLANK_ON_IDLE(1'b0)) dut_a (
    .clk(clk), .rst(rst), .req_valid(a_valid), .req_data(a_data), .req_ready(a_ready),
    .display_data(a_disp), .owner(a_owner), .busy(a_busy));

  pmodcharlie_arbiter #(.NUM_REQ(2), .CLK_FREQUENCY(1E3), .HOLD_MS(4),
                        .IDLE_PATTERN(32'hFFFF_FFFF), .BLANK_ON_IDLE(1'b1)) dut_b (
    .clk(clk), .rst(rst), .req_valid(b_valid), .req_data(b_data), .req_ready(b_ready),
    .display_data(b_disp), .owner(b_owner), .busy(b_busy));

  pmodcharlie_arbiter #(.NUM_REQ(4), .CLK_FREQUENCY(1E3), .HOLD_MS(4),
                        .IDLE_PATTERN(32'h0000_0000), .BLANK_ON_IDLE(1'b0)) dut_c (
    .clk(clk), .rst(rst), .req_valid(c_valid), .req_data(c_data), .req_ready(c_ready),
    .display_data(c_disp), .owner(c_owner), .busy(c_busy));

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // ---------------- driver tasks ----------------
  // Step to 1 time unit after the next rising edge. Registered outputs are settled there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every requester offers a word, except the one that currently holds the display.
  task automatic c_set_all_but_owner();
    c_valid = c_busy ? ~(4'b0001 << c_owner) : 4'hF;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          cur;
    int          other;
    logic [1:0]  exp_rdy;
    logic [31:0] exp_word;
    int          wait_cnt[4];
    logic [3:0]  acc;

    // Test 1: reset values; req_ready is held low during reset
    repeat (2) tick();
    a_valid = 2'b01;
    #1;
    check("a_ready_in_rst", 32'(a_ready), 32'h0);
    a_valid = 2'b00;
    rst = 1'b0;
    tick();
    check("a_idle_disp", a_disp, 32'h0000_0000);
    check("a_idle_busy", 32'(a_busy), 32'h0);
    check("a_idle_owner", 32'(a_owner), 32'h1);
    check("a_idle_ready", 32'(a_ready), 32'h0);
    check("b_idle_disp", b_disp, 32'hFFFF_FFFF);
    check("c_idle_owner", 32'(c_owner), 32'h3);

    // Test 2: single request, grant latency, hold length, word retained when idle
    a_data[31:0] = 32'h1234_5678;
    a_valid      = 2'b01;
    #1;
    check("a_t2_ready", 32'(a_ready), 32'h1);
    tick();
    check("a_t2_disp", a_disp, 32'h1234_5678);
    check("a_t2_owner", 32'(a_owner), 32'h0);
    check("a_t2_busy", 32'(a_busy), 32'h1);
    a_valid = 2'b00;
    for (int i = 1; i <= HC; i++) begin
      tick();
      check("a_t2_hold_busy", 32'(a_busy), (i < HC) ? 32'h1 : 32'h0);
    end
    check("a_t2_keep", a_disp, 32'h1234_5678);

    // Test 1b: reset in HOLD ends ownership and refuses the pending handshake
    a_data[31:0] = 32'h5555_AAAA;
    a_valid      = 2'b01;
    tick();
    check("a_t1b_busy", 32'(a_busy), 32'h1);
    tick();
    rst = 1'b1;
    #1;
    check("a_t1b_ready_rst", 32'(a_ready), 32'h0);
    tick();
    check("a_t1b_busy_rst", 32'(a_busy), 32'h0);
    check("a_t1b_disp_rst", a_disp, 32'h0000_0000);
    a_valid = 2'b00;
    rst     = 1'b0;
    tick();

    // Test 3: two requesters alternate. Each drops out while it holds the display.
    a_data  = {32'hBBBB_BBBB, 32'hAAAA_AAAA};
    a_valid = 2'b11;
    #1;
    check("a_t3_first_ready", 32'(a_ready), 32'h1);
    tick();
    check("a_t3_first_disp", a_disp, 32'hAAAA_AAAA);
    cur = 0;
    repeat (3) begin
      other    = 1 - cur;
      exp_rdy  = (other == 1) ? 2'b10 : 2'b01;
      exp_word = (other == 1) ? 32'hBBBB_BBBB : 32'hAAAA_AAAA;
      a_valid  = exp_rdy;
      repeat (HC - 1) begin
        #1;
        check("a_t3_wait_ready", 32'(a_ready), 32'h0);
        tick();
      end
      #1;
      check("a_t3_exp_ready", 32'(a_ready), 32'(exp_rdy));
      tick();
      check("a_t3_disp", a_disp, exp_word);
      check("a_t3_owner", 32'(a_owner), 32'(other));
      cur = other;
    end
    a_valid = 2'b00;
    repeat (HC) tick();
    check("a_t3_idle", 32'(a_busy), 32'h0);

    // Test 4: owner refreshes its word at timer=1. Requester 1 waits another full hold.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    a_data  = {32'hBBBB_BBBB, 32'h1111_0000};
    a_valid = 2'b01;
    #1;
    check("a_t4_ready0", 32'(a_ready), 32'h1);
    tick();
    check("a_t4_disp0", a_disp, 32'h1111_0000);
    a_valid = 2'b10;
    #1;
    check("a_t4_t3_ready", 32'(a_ready), 32'h0);
    tick();
    #1;
    check("a_t4_t2_ready", 32'(a_ready), 32'h0);
    tick();
    a_data[31:0] = 32'hDEAD_BEEF;
    a_valid      = 2'b11;
    #1;
    check("a_t4_refresh_ready", 32'(a_ready), 32'h1);
    tick();
    check("a_t4_refresh_disp", a_disp, 32'hDEAD_BEEF);
    check("a_t4_refresh_owner", 32'(a_owner), 32'h0);
    a_valid = 2'b10;
    repeat (HC - 1) begin
      #1;
      check("a_t4_wait_ready", 32'(a_ready), 32'h0);
      tick();
    end
    #1;
    check("a_t4_exp_ready", 32'(a_ready), 32'h2);
    tick();
    check("a_t4_disp1", a_disp, 32'hBBBB_BBBB);
    check("a_t4_owner1", 32'(a_owner), 32'h1);
    a_valid = 2'b00;
    repeat (HC) tick();

    // Test 5: blanking to IDLE_PATTERN when the hold lapses
    b_data[31:0] = 32'h0BAD_F00D;
    b_valid      = 2'b01;
    #1;
    check("b_t5_ready", 32'(b_ready), 32'h1);
    tick();
    check("b_t5_disp", b_disp, 32'h0BAD_F00D);
    b_valid = 2'b00;
    repeat (HC - 1) tick();
    check("b_t5_hold_disp", b_disp, 32'h0BAD_F00D);
    check("b_t5_hold_busy", 32'(b_busy), 32'h1);
    tick();
    check("b_t5_blank", b_disp, 32'hFFFF_FFFF);
    check("b_t5_busy", 32'(b_busy), 32'h0);

    // Test 6a: four requesters, grant order 0,1,2,3,0
    c_data = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        repeat (HC - 1) begin
          c_set_all_but_owner();
          #1;
          check("c_rr_wait_ready", 32'(c_ready), 32'h0);
          tick();
        end
      end
      c_set_all_but_owner();
      #1;
      check("c_rr_ready", 32'(c_ready), 32'(4'b0001 << (k % 4)));
      tick();
      check("c_rr_owner", 32'(c_owner), 32'(k % 4));
      exp_word = 32'h1111_1111 * 32'((k % 4) + 1);
      check("c_rr_disp", c_disp, exp_word);
    end

    // Test 6b: random requests. A raised request stays up until it is accepted.
    // The current owner does not raise a request during its own hold.
    c_valid = '0;
    for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
    repeat (10000) begin
      for (int i = 0; i < 4; i++) begin
        if (!c_valid[i] && !(c_busy && (int'(c_owner) == i)) && ($urandom_range(0, 3) == 0)) begin
          c_valid[i]         = 1'b1;
          c_data[32*i +: 32] = $urandom();
          wait_cnt[i]        = 0;
        end
      end
      #1;
      check("c_onehot", 32'($countones(c_ready) <= 1), 32'h1);
      acc = c_valid & c_ready;
      for (int i = 0; i < 4; i++) begin
        if (acc[i]) begin
          check("c_starve", 32'(wait_cnt[i] <= 3 * HC), 32'h1);
          exp_q.push_back(c_data[32*i +: 32]);
        end else if (c_valid[i]) begin
          wait_cnt[i]++;
        end
      end
      tick();
      if (acc != '0) begin
        check("c_sb_disp", c_disp, exp_q.pop_front());
      end
      c_valid = c_valid & ~acc;
    end

    // ---------------- final report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
